// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer between the UART receiver and the host/test interface.
// Each cycle with Data_Rdy high writes one word. The oldest entry is shown
// on Data_Out/Err_Out without being popped, and each cycle with Read_Done
// high pops one entry. A write that arrives while the FIFO is full, with no
// pop in the same cycle, is dropped and sets the sticky FIFO_Overflow flag.
//
// Configuration macro: UART_RX_FIFO_ERR_STORE_EN
//   defined   : each entry also stores Rx_Error, which is shown on Err_Out
//   undefined : Rx_Error is ignored and Err_Out is constant 3'b000
//
// Parameters:
//   DATA_BITS   width of each received data word
//   FIFO_DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   SysClk         in   system clock, rising edge
//   Rst            in   asynchronous active-high reset
//   Rx_Data        in   received word
//   Data_Rdy       in   write strobe, one entry per high cycle
//   Rx_Error       in   receiver status {break, frame, parity}
//   Read_Done      in   pop strobe, one entry per high cycle
//   Data_Out       out  head entry data (0 while empty)
//   Err_Out        out  head entry error status (0 while empty)
//   FIFO_Empty     out  no entries stored
//   FIFO_Full      out  FIFO_DEPTH entries stored
//   FIFO_Overflow  out  sticky: a write was dropped
//   Count          out  number of stored entries
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          SysClk,
    input  logic                          Rst,
    input  logic [DATA_BITS-1:0]          Rx_Data,
    input  logic                          Data_Rdy,
    input  logic [2:0]                    Rx_Error,
    input  logic                          Read_Done,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic [2:0]                    Err_Out,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef UART_RX_FIFO_ERR_STORE_EN
    localparam int ENTRY_W = DATA_BITS + 3;
`else
    localparam int ENTRY_W = DATA_BITS;
`endif

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic empty;
    logic full;
    logic do_pop;
    logic do_write;
    logic overflow_evt;

    // Flags decode from the registered occupancy counter only.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop on a full FIFO frees the slot the simultaneous write lands in,
    // so the write is accepted. A pop on an empty FIFO is simply ignored.
    assign do_pop       = Read_Done && !empty;
    assign do_write     = Data_Rdy && (!full || Read_Done);
    assign overflow_evt = Data_Rdy && full && !Read_Done;

`ifdef UART_RX_FIFO_ERR_STORE_EN
    assign wr_entry = {Rx_Error, Rx_Data};
`else
    assign wr_entry = Rx_Data;
    // Rx_Error has no destination in this build.
    logic unused_rx_error;
    assign unused_rx_error = ^Rx_Error;
`endif

    // NOTE: the storage array has no reset; its contents are never visible
    // while empty, so clearing it would only add reset fan-out.
    always_ff @(posedge SysClk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // NOTE: non-blocking assignments throughout so every register updates
    // from the pre-edge values regardless of statement order.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({do_write, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            // A drop on this edge wins over a clearing pop on this edge.
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end else if (do_pop) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head_entry = mem[rd_ptr];

    assign Data_Out = empty ? '0 : head_entry[DATA_BITS-1:0];

`ifdef UART_RX_FIFO_ERR_STORE_EN
    assign Err_Out = empty ? 3'b000 : head_entry[DATA_BITS+2:DATA_BITS];
`else
    assign Err_Out = 3'b000;
`endif

    assign FIFO_Empty    = empty;
    assign FIFO_Full     = full;
    assign FIFO_Overflow = overflow_q;
    assign Count         = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo (DATA_BITS=8, FIFO_DEPTH=8).
// Directed vector table, hand-written corner sequences, then randomized
// traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          SysClk;
    logic          Rst;
    logic [DW-1:0] Rx_Data;
    logic          Data_Rdy;
    logic [2:0]    Rx_Error;
    logic          Read_Done;
    logic [DW-1:0] Data_Out;
    logic [2:0]    Err_Out;
    logic          FIFO_Empty;
    logic          FIFO_Full;
    logic          FIFO_Overflow;
    logic [CW-1:0] Count;

    uart_rx_fifo #(
        .DATA_BITS  (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Rx_Data       (Rx_Data),
        .Data_Rdy      (Data_Rdy),
        .Rx_Error      (Rx_Error),
        .Read_Done     (Read_Done),
        .Data_Out      (Data_Out),
        .Err_Out       (Err_Out),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .Count         (Count)
    );

    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge SysClk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of {err, data} plus the sticky flag.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]    err;
        logic [DW-1:0] data;
    } entry_t;

    entry_t m_q[$];
    logic   m_ovf;

    function automatic logic [2:0] stored_err(input logic [2:0] e);
`ifdef UART_RX_FIFO_ERR_STORE_EN
        return e;
`else
        return 3'b000;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic rd,
                              input logic [DW-1:0] d, input logic [2:0] e);
        bit was_full;
        bit was_empty;
        entry_t ent;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (rd && !was_empty) begin
            void'(m_q.pop_front());
            m_ovf = 1'b0;
        end
        if (wr && was_full && !rd) begin
            m_ovf = 1'b1;
        end else if (wr) begin
            ent.err  = stored_err(e);
            ent.data = d;
            m_q.push_back(ent);
        end
    endtask

    task automatic model_compare(input string tag);
        logic [DW-1:0] ed;
        logic [2:0]    ee;
        ed = (m_q.size() == 0) ? '0 : m_q[0].data;
        ee = (m_q.size() == 0) ? 3'b000 : m_q[0].err;
        check({tag, ".count"}, 32'(Count), 32'(m_q.size()));
        check({tag, ".data"},  32'(Data_Out), 32'(ed));
        check({tag, ".err"},   32'(Err_Out), 32'(ee));
        check({tag, ".empty"}, 32'(FIFO_Empty), 32'(m_q.size() == 0));
        check({tag, ".full"},  32'(FIFO_Full), 32'(m_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(FIFO_Overflow), 32'(m_ovf));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic [CW-1:0] exp_count;
        logic [DW-1:0] exp_data;
        logic          exp_empty;
        logic          exp_full;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [DW-1:0] d,
                                input int cnt, input logic [DW-1:0] xd,
                                input logic xe, input logic xf, input logic xo);
        vec_t v;
        v.wr = wr; v.rd = rd; v.data = d;
        v.exp_count = CW'(cnt); v.exp_data = xd;
        v.exp_empty = xe; v.exp_full = xf; v.exp_ovf = xo;
        return v;
    endfunction

    task automatic idle_inputs();
        Data_Rdy  = 1'b0;
        Read_Done = 1'b0;
        Rx_Data   = '0;
        Rx_Error  = 3'b000;
    endtask

    initial begin
        logic [DW-1:0] v;
        int pw;
        int pr;

        idle_inputs();
        Rst = 1'b1;
        #2;
        check("reset.count", 32'(Count), 0);
        check("reset.data",  32'(Data_Out), 0);
        check("reset.err",   32'(Err_Out), 0);
        check("reset.empty", 32'(FIFO_Empty), 1);
        check("reset.full",  32'(FIFO_Full), 0);
        check("reset.ovf",   32'(FIFO_Overflow), 0);
        cycle();
        Rst = 1'b0;
        cycle();

        // ---- table: single word, fill, overflow, drain, full+simultaneous
        vecs.push_back(mk(1, 0, 8'hA5, 1, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 8'(i), i + 1, 8'h00, 0, (i == 7), 0));
        vecs.push_back(mk(1, 0, 8'hFF, 8, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8, 8'h00, 0, 1, 1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 8'h00, 7 - i, (i < 7) ? 8'(i + 1) : 8'h00, (i == 7), 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 8'(8'h60 + i), i + 1, 8'h60, 0, (i == 7), 0));
        vecs.push_back(mk(1, 1, 8'h55, 8, 8'h61, 0, 1, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 8'h00, 7 - k,
                              (k < 6) ? 8'(8'h62 + k) : ((k == 6) ? 8'h55 : 8'h00),
                              (k == 7), 0, 0));

        foreach (vecs[i]) begin
            Data_Rdy  = vecs[i].wr;
            Read_Done = vecs[i].rd;
            Rx_Data   = vecs[i].data;
            Rx_Error  = 3'b000;
            cycle();
            check($sformatf("vec%0d.count", i), 32'(Count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d.data", i),  32'(Data_Out), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d.empty", i), 32'(FIFO_Empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d.full", i),  32'(FIFO_Full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d.ovf", i),   32'(FIFO_Overflow), 32'(vecs[i].exp_ovf));
        end
        idle_inputs();

        // ---- pointer wrap: alternating write / pop, 0x10..0x23
        for (int i = 0; i < 20; i++) begin
            v = 8'(8'h10 + i);
            Data_Rdy = 1'b1; Rx_Data = v;
            cycle();
            Data_Rdy = 1'b0;
            check($sformatf("wrap%0d.count_w", i), 32'(Count), 1);
            Read_Done = 1'b1;
            #1;
            check($sformatf("wrap%0d.data", i), 32'(Data_Out), 32'(v));
            cycle();
            Read_Done = 1'b0;
            check($sformatf("wrap%0d.count_r", i), 32'(Count), 0);
        end
        idle_inputs();

        // ---- error status capture
        Data_Rdy = 1'b1; Rx_Data = 8'h3C; Rx_Error = 3'b010;
        cycle();
        idle_inputs();
        check("err.data", 32'(Data_Out), 32'h3C);
        check("err.err",  32'(Err_Out), 32'(stored_err(3'b010)));
        Read_Done = 1'b1;
        cycle();
        idle_inputs();
        check("err.empty_after", 32'(FIFO_Empty), 1);
        check("err.err_after",   32'(Err_Out), 0);

        // ---- async reset mid-cycle with 5 entries
        for (int i = 0; i < 5; i++) begin
            Data_Rdy = 1'b1; Rx_Data = 8'(8'hB0 + i);
            cycle();
        end
        idle_inputs();
        check("arst.count_before", 32'(Count), 5);
        #2;
        Rst = 1'b1;
        #1;
        check("arst.count", 32'(Count), 0);
        check("arst.empty", 32'(FIFO_Empty), 1);
        check("arst.full",  32'(FIFO_Full), 0);
        check("arst.ovf",   32'(FIFO_Overflow), 0);
        check("arst.data",  32'(Data_Out), 0);
        cycle();
        Rst = 1'b0;
        Read_Done = 1'b1;
        cycle();
        Read_Done = 1'b0;
        check("pop_empty.count", 32'(Count), 0);
        check("pop_empty.empty", 32'(FIFO_Empty), 1);
        check("pop_empty.ovf",   32'(FIFO_Overflow), 0);
        check("pop_empty.data",  32'(Data_Out), 0);

        // ---- randomized traffic against the reference model
        model_reset();
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin pw = 50; pr = 50; end
                1: begin pw = 85; pr = 25; end  // drives into full / overflow
                2: begin pw = 20; pr = 80; end  // drains, pops while empty
                default: begin pw = 70; pr = 60; end
            endcase
            for (int c = 0; c < 500; c++) begin
                Data_Rdy  = ($urandom_range(99) < pw);
                Read_Done = ($urandom_range(99) < pr);
                Rx_Data   = DW'($urandom);
                Rx_Error  = 3'($urandom);
                model_step(Data_Rdy, Read_Done, Rx_Data, Rx_Error);
                cycle();
                model_compare($sformatf("rnd%0d_%0d", seg, c));
            end
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the host/test interface. Captures each byte the receiver flags with `Data_Rdy`, along with its 3-bit `Rx_Error` status when configured. Presents the oldest entry show-ahead on `Data_Out`; the consumer strobes `Read_Done` to advance to the next entry. Reports `FIFO_Empty`, `FIFO_Full` and a sticky `FIFO_Overflow` for the interface tasks and the BIST.

## Interface
Parameters:
- `DATA_BITS`, 8, width of each received data word.
- `FIFO_DEPTH`, 8, number of entries; must be a power of two and at least 2.

Ports:
- `SysClk`  in  1  system clock; all state updates on its rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Rx_Data`  in  DATA_BITS  received word from the receiver.
- `Data_Rdy`  in  1  write strobe; each high cycle writes one entry.
- `Rx_Error`  in  3  receiver error status for `Rx_Data`: bit0 parity, bit1 frame, bit2 break.
- `Read_Done`  in  1  pop strobe; each high cycle pops one entry.
- `Data_Out`  out  DATA_BITS  head entry data.
- `Err_Out`  out  3  head entry error status.
- `FIFO_Empty`  out  1  no entries stored.
- `FIFO_Full`  out  1  FIFO_DEPTH entries stored.
- `FIFO_Overflow`  out  1  sticky flag: a write was dropped.
- `Count`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.

## Operation
- Storage is a circular buffer with read and write pointers of width $clog2(FIFO_DEPTH).
- Both pointers wrap from FIFO_DEPTH-1 to 0.
- `Count` is a separate registered occupancy counter with range 0..FIFO_DEPTH.
- Write (`Data_Rdy`=1):
  - Not full: store `{Rx_Error, Rx_Data}` at the write pointer, increment the pointer, `Count`+1.
  - Full, no pop in the same cycle: the word is discarded, pointers and `Count` are unchanged, and `FIFO_Overflow` is set.
- Pop (`Read_Done`=1):
  - Not empty: increment the read pointer, `Count`-1.
  - Empty: ignored, with no state change and no flag change.
- Simultaneous write and pop:
  - Not empty: both happen and `Count` is unchanged.
  - Full: both happen and there is no overflow.
  - Empty: the write happens and the pop is ignored, so `Count` becomes 1.
- Bytes with a nonzero `Rx_Error` are stored like any other byte. This block never filters them.
- `FIFO_Overflow` stays set until reset or until the first successful pop after it was set. A pop clears it on that edge, unless an overflow occurs on the same edge, in which case it stays set.
- `FIFO_Empty` = (`Count`==0) and `FIFO_Full` = (`Count`==FIFO_DEPTH). Both are decoded from registered state with no input-to-flag combinational path.
- Head outputs:
  - Not empty: `Data_Out`/`Err_Out` = entry at the read pointer.
  - Empty: both are forced to 0.
- Reset mid-operation: all contents are abandoned immediately. Pointers, `Count` and the flags return to their reset values asynchronously. Memory contents need not be cleared because the outputs are masked while empty.

## Timing
- Reset values:
  - `Data_Out`=0, `Err_Out`=0, `Count`=0.
  - `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0.
- Write latency: for a write sampled at edge N into an empty FIFO, `FIFO_Empty` falls and `Data_Out` shows the word in the cycle after edge N.
- Pop latency: for a pop at edge N, the next entry (or 0 if the FIFO is now empty) appears on `Data_Out` after edge N.
- The consumer samples `Data_Out` while `Read_Done` is high. The strobe and the data are therefore consistent in the same cycle.
- Multi-cycle `Data_Rdy` or `Read_Done` pulses act as one operation per cycle. The receiver guarantees single-cycle `Data_Rdy`.
- No combinational path from any input to any output, except the masking of the head outputs by the registered empty state.

## Configuration
- `UART_RX_FIFO_ERR_STORE_EN` defined:
  - Each entry is DATA_BITS+3 bits wide.
  - `Err_Out` carries the stored `Rx_Error` of the head entry.
- Not defined:
  - Entries are DATA_BITS wide and `Rx_Error` is ignored.
  - `Err_Out` is constant 3'b000.
  - All other behaviour is identical.

## Test plan
- Reset, then write 8'hA5 with `Rx_Error`=0 → next cycle `FIFO_Empty`=0, `Count`=1, `Data_Out`=8'hA5. Pop → `FIFO_Empty`=1, `Data_Out`=0.
- Write 0..7 (DEPTH=8) → `FIFO_Full`=1, `Count`=8. Write 8'hFF → `FIFO_Overflow`=1, `Count`=8. Pop 8 times → 0..7 in order; `Overflow` clears on the first pop; `FIFO_Empty`=1 at the end.
- Pointer wrap: 20 cycles of alternating write/pop with values 0x10..0x23 → every value is read back in order and `Count` never exceeds 1.
- Full FIFO with simultaneous write 8'h55 and pop → `Count` stays 8 with no overflow. After draining, 8'h55 is the last word out.
- Macro defined: write 8'h3C with `Rx_Error`=3'b010 → `Err_Out`=3'b010 with that head entry. Macro undefined: `Err_Out`=0.
- Assert `Rst` asynchronously with 5 entries stored, mid-cycle → flags and `Count` reset immediately, without waiting for a clock edge. Pop while empty → no change.
